// File: rtl/alu_bist_if.sv
// Controller <-> ALU/top-level bundle for the ALU BIST sequencer.
// master = BIST controller, slave = ALU datapath and top-level mux side.
interface alu_bist_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic [WIDTH-1:0] tpg_a;
    logic [WIDTH-1:0] tpg_b;
    logic             tpg_cin;
    logic [1:0]       tpg_sel;
    logic             bist_mode;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;

    modport master (
        input  start, alu_result, alu_cout,
        output tpg_a, tpg_b, tpg_cin, tpg_sel, bist_mode, busy, done, pass, signature
    );

    modport slave (
        output start, alu_result, alu_cout,
        input  tpg_a, tpg_b, tpg_cin, tpg_sel, bist_mode, busy, done, pass, signature
    );
endinterface

// File: rtl/alu_bist_controller.sv
// ALU BIST sequencer: LFSR pattern generation, MISR response compaction, golden compare.
// Latency: done rises 4*PATTERNS_PER_OP+2 cycles after busy; one pattern per cycle.
// Backpressure: none; start is ignored while a run is in progress (no abort).
module alu_bist_controller #(
    parameter int               WIDTH           = 16,
    parameter int               PATTERNS_PER_OP = 256,
    parameter logic [WIDTH-1:0] SEED_A          = 16'hACE1,
    parameter logic [WIDTH-1:0] SEED_B          = 16'h1D2B,
    parameter logic [WIDTH-1:0] MISR_SEED       = 16'h0000,
    parameter logic [WIDTH-1:0] GOLDEN_SIG      = 16'h0000
) (
    input  logic      clk,
    input  logic      rst,
    alu_bist_if.master bus
);
    localparam int PW = $clog2(PATTERNS_PER_OP);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [PW-1:0]    pattern_cnt;
    logic [1:0]       op_cnt;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [WIDTH-1:0] misr;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             bist_q;

    logic             pattern_wrap;
    logic             last_pattern;
    logic [WIDTH-1:0] response;

    // Shared polynomial for both pattern LFSRs and the MISR shift path.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], q[WIDTH-1] ^ q[WIDTH-3] ^ q[WIDTH-4] ^ q[WIDTH-6]};
    endfunction

    assign pattern_wrap = (pattern_cnt == PW'(PATTERNS_PER_OP - 1));
    assign last_pattern = pattern_wrap && (op_cnt == 2'b11);
    assign response     = bus.alu_result ^ {{(WIDTH-1){1'b0}}, bus.alu_cout};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pattern_cnt <= '0;
            op_cnt      <= '0;
            lfsr_a      <= SEED_A;
            lfsr_b      <= SEED_B;
            misr        <= MISR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            bist_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_INIT;
                        busy_q <= 1'b1;
                        bist_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                    end
                end
                S_INIT: begin
                    lfsr_a      <= SEED_A;
                    lfsr_b      <= SEED_B;
                    misr        <= MISR_SEED;
                    pattern_cnt <= '0;
                    op_cnt      <= '0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    // The ALU is combinational: this edge captures the response to
                    // the pattern currently on tpg_* and presents the next one.
                    lfsr_a      <= lfsr_next(lfsr_a);
                    lfsr_b      <= lfsr_next(lfsr_b);
                    misr        <= lfsr_next(misr) ^ response;
                    pattern_cnt <= pattern_cnt + PW'(1);
                    if (pattern_wrap) begin
                        op_cnt <= op_cnt + 2'd1;
                    end
                    if (last_pattern) begin
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    pass_q <= (misr == GOLDEN_SIG);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    bist_q <= 1'b0;
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tpg_a     = lfsr_a;
    assign bus.tpg_b     = lfsr_b;
    assign bus.tpg_cin   = pattern_cnt[0];
    assign bus.tpg_sel   = op_cnt;
    assign bus.bist_mode = bist_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr;
endmodule
